memp_row_packer: RTL and testbench
==================================

# memp_row_packer

Write-side front end for the P-vector row memory: accepts a stream of scalar results one element per handshake, packs `no_of_units` consecutive elements into one memory row, and issues single-cycle row writes (`write_enable` / address / data) to the row memory's write port. It sits between the vector-update datapath and the memory, and signals `finish` once the whole vector has been written.

## Interface
- `element_width`, 64: width of one scalar element.
- `no_of_units`, 8: elements per memory row (lanes).
- `address_width`, 20: row address width.
- `number_of_elements`, 72: elements per run (vector length); must be ≥1.
- `base_address`, 0: row address of the first written row.

- `clk`  in  1  clock; all state is updated on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  run request; sampled only in IDLE.
- `in_valid`  in  1  element present on `in_data`.
- `in_data`  in  element_width  scalar element.
- `in_ready`  out  1  packer can accept; an element transfers on an edge where `in_valid & in_ready`.
- `write_enable`  out  1  one-cycle row write strobe to the memory.
- `output_write_address`  out  address_width  row address for the current write.
- `output_data`  out  no_of_units*element_width  packed row; lane k is bits [k*element_width +: element_width].
- `busy`  out  1  high in FILL and DRAIN.
- `finish`  out  1  run complete; sticky until the next accepted `start`.
- `checksum`  out  element_width  XOR of accepted elements (see Configuration).

## Operation
- States: IDLE, FILL, DRAIN.
- IDLE: `in_ready`=0. On `start`=1: clear `finish`, lane counter, element counter and checksum; load the row address with `base_address`; go to FILL.
- FILL: `in_ready`=1 continuously. Each accepted element is written into the assembly register at the current lane, then the lane counter increments.
- A row completes when the accepted element is in lane `no_of_units-1`, or when it is element `number_of_elements-1`. On completion:
  - The assembly row, including the element just accepted, is copied to `output_data`. Unfilled lanes are zero.
  - `output_write_address` is set to the current row address, and `write_enable` is pulsed on the next cycle.
  - The row address increments, the lane counter returns to 0, and the assembly register clears.
  - Accepting continues without a bubble.
- Last element accepted: go to DRAIN. `in_ready` drops on the same edge, so no element is accepted beyond `number_of_elements`.
- DRAIN lasts one cycle, during which the final `write_enable` is high. The state then returns to IDLE with `finish`=1.
- `start` is ignored in FILL and DRAIN.
- The row address wraps modulo 2^address_width; no error is flagged.
- Row count is ceil(number_of_elements / no_of_units).

## Timing
- Reset values: `in_ready`=0, `write_enable`=0, `output_write_address`=0, `output_data`=0, `busy`=0, `finish`=0, `checksum`=0, state IDLE.
- Reset asserted mid-run: the partial row is discarded, no write is issued, and the block stays in IDLE until a new `start`.
- `start` sampled at edge S: `in_ready`=1 and `busy`=1 from S+1.
- Row-completing accept at edge N:
  - `write_enable`=1 during cycle N..N+1 only.
  - `output_write_address` and `output_data` are valid in that same cycle and held until the next write.
- Throughput: one element per cycle sustained. Back-to-back rows produce `write_enable` pulses exactly `no_of_units` cycles apart.
- `finish` rises one edge after the final `write_enable` cycle.
- `in_valid` gaps only stretch the schedule; row contents do not change.

## Configuration
- `MEMP_PACKER_CHECKSUM_EN` defined: `checksum` holds the running XOR of every accepted `in_data`. It clears on accepted `start`, updates on each accept, and is final when `finish` rises.
- Not defined: `checksum` is tied to 0, and no accumulator logic is generated.

## Test plan
- Reset, then idle for 10 cycles → all outputs 0, `in_ready`=0. Also hold `start`=0 and drive `in_valid`=1 → no write occurs.
- `number_of_elements`=16, `base_address`=0x10, `in_valid` held high, data = 1..16 → 2 writes, 8 cycles apart:
  - address 0x10 with lanes = 1..8;
  - address 0x11 with lanes = 9..16;
  - `finish`=1 one cycle after the second write.
- `number_of_elements`=10, data 1..10 → address 0 row = 1..8; address 1 row has lanes 0–1 = 9,10 and lanes 2–7 = 0. Exactly 2 writes; `in_ready`=0 after the 10th accept.
- Same as the 16-element case but with `in_valid` toggling 1,0,0,1,… → identical addresses and data. Each write follows its row's 8th accept by one cycle.
- Reset asserted after 5 accepts → no `write_enable`, `finish`=0. A new `start` then writes its first row at `base_address`. A `start` pulse mid-FILL has no effect on counters.
- With `MEMP_PACKER_CHECKSUM_EN`, 16 elements 1..16 → `checksum`=0x10 at `finish`. Without the macro → `checksum`=0 throughout.

Source files
------------

// File: rtl/memp_row_packer.sv
// memp_row_packer: packs a stream of scalar elements into no_of_units-wide rows
// and issues one-cycle row writes. Optional XOR checksum: MEMP_PACKER_CHECKSUM_EN.
module memp_row_packer #(
  parameter int                       element_width      = 64,
  parameter int                       no_of_units        = 8,
  parameter int                       address_width      = 20,
  parameter int                       number_of_elements = 72,
  parameter logic [address_width-1:0] base_address       = '0
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  start,
  input  logic                                  in_valid,
  input  logic [element_width-1:0]              in_data,
  output logic                                  in_ready,
  output logic                                  write_enable,
  output logic [address_width-1:0]              output_write_address,
  output logic [no_of_units*element_width-1:0]  output_data,
  output logic                                  busy,
  output logic                                  finish,
  output logic [element_width-1:0]              checksum,
  output logic [1:0]                            dbg_state
);

  localparam int ROW_W  = no_of_units * element_width;
  localparam int LANE_W = (no_of_units > 1) ? $clog2(no_of_units) : 1;
  localparam int CNT_W  = $clog2(number_of_elements + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  // Handshake: an element transfers on a rising edge where in_valid & in_ready.
  // in_ready is registered and is only ever high in FILL.
  state_t                   r_state;
  logic [LANE_W-1:0]        r_lane;
  logic [CNT_W-1:0]         r_count;
  logic [address_width-1:0] r_addr;
  logic [ROW_W-1:0]         r_assembly;
  logic                     r_in_ready;
  logic                     r_we;
  logic [address_width-1:0] r_wr_addr;
  logic [ROW_W-1:0]         r_wr_data;
  logic                     r_busy;
  logic                     r_finish;

  logic             w_accept;
  logic             w_last_lane;
  logic             w_last_elem;
  logic [ROW_W-1:0] w_row;

  assign w_accept    = r_in_ready & in_valid;
  assign w_last_lane = (r_lane == LANE_W'(no_of_units - 1));
  assign w_last_elem = (r_count == CNT_W'(number_of_elements - 1));

  // Assembly row with the incoming element merged into the current lane.
  always_comb begin
    w_row = r_assembly;
    for (int k = 0; k < no_of_units; k++) begin
      if (r_lane == LANE_W'(k)) begin
        w_row[k*element_width +: element_width] = in_data;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_lane     <= '0;
      r_count    <= '0;
      r_addr     <= '0;
      r_assembly <= '0;
      r_in_ready <= 1'b0;
      r_we       <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_busy     <= 1'b0;
      r_finish   <= 1'b0;
    end else begin
      r_we <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_finish   <= 1'b0;
            r_lane     <= '0;
            r_count    <= '0;
            r_addr     <= base_address;
            r_assembly <= '0;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b1;
            r_state    <= S_FILL;
          end
        end
        S_FILL: begin
          if (w_accept) begin
            r_count <= r_count + CNT_W'(1);
            if (w_last_lane || w_last_elem) begin
              r_wr_data  <= w_row;
              r_wr_addr  <= r_addr;
              r_we       <= 1'b1;
              r_addr     <= r_addr + address_width'(1);
              r_lane     <= '0;
              r_assembly <= '0;
            end else begin
              r_assembly <= w_row;
              r_lane     <= r_lane + LANE_W'(1);
            end
            if (w_last_elem) begin
              r_in_ready <= 1'b0;
              r_state    <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          // The final row write is on the bus during this cycle.
          r_busy   <= 1'b0;
          r_finish <= 1'b1;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef MEMP_PACKER_CHECKSUM_EN
  logic [element_width-1:0] r_checksum;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_checksum <= '0;
    end else if (r_state == S_IDLE && start) begin
      r_checksum <= '0;
    end else if (r_state == S_FILL && w_accept) begin
      r_checksum <= r_checksum ^ in_data;
    end
  end

  assign checksum = r_checksum;
`else
  assign checksum = '0;
`endif

  assign in_ready             = r_in_ready;
  assign write_enable         = r_we;
  assign output_write_address = r_wr_addr;
  assign output_data          = r_wr_data;
  assign busy                 = r_busy;
  assign finish               = r_finish;
  assign dbg_state            = r_state;

endmodule

// File: tb/tb_memp_row_packer.sv
// Bench for memp_row_packer: two instances (16 elements at base 0x10, 10 elements
// at base 0) share one input stream; monitors pop expected rows from queues.
module tb_memp_row_packer;

  localparam int EW = 64;
  localparam int NU = 8;
  localparam int AW = 20;
  localparam int RW = NU * EW;
  localparam int XW = AW + RW;
  localparam int NA = 16;
  localparam int NB = 10;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic [EW-1:0] in_data = '0;

  logic          rdy_a, we_a, busy_a, fin_a;
  logic [AW-1:0] addr_a;
  logic [RW-1:0] data_a;
  logic [EW-1:0] cs_a;
  logic [1:0]    st_a;
  logic          rdy_b, we_b, busy_b, fin_b;
  logic [AW-1:0] addr_b;
  logic [RW-1:0] data_b;
  logic [EW-1:0] cs_b;
  logic [1:0]    st_b;

  memp_row_packer #(
    .element_width(EW), .no_of_units(NU), .address_width(AW),
    .number_of_elements(NA), .base_address(20'h10)
  ) dut_a (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy_a), .write_enable(we_a), .output_write_address(addr_a),
    .output_data(data_a), .busy(busy_a), .finish(fin_a), .checksum(cs_a),
    .dbg_state(st_a)
  );

  memp_row_packer #(
    .element_width(EW), .no_of_units(NU), .address_width(AW),
    .number_of_elements(NB), .base_address(20'h0)
  ) dut_b (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy_b), .write_enable(we_b), .output_write_address(addr_b),
    .output_data(data_b), .busy(busy_b), .finish(fin_b), .checksum(cs_b),
    .dbg_state(st_b)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [XW-1:0] exp_q_a[$];
  logic [XW-1:0] exp_q_b[$];
  int we_hist_a[$];
  int acc_a = 0, acc_b = 0;
  int row_acc_a = 0, row_acc_b = 0;
  int last_we_a = 0, last_we_b = 0;

  task automatic check(input string name, input logic [XW-1:0] act, input logic [XW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      acc_a = 0;
      acc_b = 0;
    end else begin
      if (we_a) begin
        if (exp_q_a.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL a_unexpected_write: got write at addr %0h expected none", addr_a);
        end else begin
          check("a_row", {addr_a, data_a}, exp_q_a.pop_front());
        end
        check("a_we_lag", XW'(cyc - row_acc_a), XW'(1));
        last_we_a = cyc;
        we_hist_a.push_back(cyc);
      end
      if (we_b) begin
        if (exp_q_b.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL b_unexpected_write: got write at addr %0h expected none", addr_b);
        end else begin
          check("b_row", {addr_b, data_b}, exp_q_b.pop_front());
        end
        check("b_we_lag", XW'(cyc - row_acc_b), XW'(1));
        last_we_b = cyc;
      end
      if (start && !busy_a) acc_a = 0;
      if (start && !busy_b) acc_b = 0;
      if (in_valid && rdy_a) begin
        acc_a++;
        if (acc_a % NU == 0 || acc_a == NA) row_acc_a = cyc;
      end
      if (in_valid && rdy_b) begin
        acc_b++;
        if (acc_b % NU == 0 || acc_b == NB) row_acc_b = cyc;
      end
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [RW-1:0] make_row(input int first, input int r, input int n);
    logic [RW-1:0] row;
    row = '0;
    for (int k = 0; k < NU; k++) begin
      if (r * NU + k < n) row[k*EW +: EW] = EW'(first + r * NU + k);
    end
    return row;
  endfunction

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic feed_one(input int value, input bit mid_start);
    bit got;
    int t;
    got = 1'b0;
    t = 0;
    in_valid = 1'b1;
    in_data  = EW'(value);
    start    = mid_start;
    while (!got && t < 20) begin
      @(negedge clk);
      got = rdy_a;
      @(posedge clk); #1;
      t++;
    end
    start    = 1'b0;
    in_valid = 1'b0;
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: got no accept for %0d expected accept within 20 cycles", value);
    end
  endtask

  task automatic run(input int first, input int gap, input int mid_start_at);
    logic [EW-1:0] xa, xb;
    int t;
    xa = '0;
    xb = '0;
    for (int r = 0; r < 2; r++) begin
      exp_q_a.push_back({AW'(32'h10 + r), make_row(first, r, NA)});
      exp_q_b.push_back({AW'(r), make_row(first, r, NB)});
    end
    for (int i = 0; i < NA; i++) xa ^= EW'(first + i);
    for (int i = 0; i < NB; i++) xb ^= EW'(first + i);
    we_hist_a.delete();
    pulse_start();
    for (int i = 0; i < NA; i++) begin
      feed_one(first + i, (i == mid_start_at));
      if (i < NA - 1) repeat (gap) begin @(posedge clk); #1; end
    end
    t = 0;
    while (!fin_a && t < 30) begin
      @(negedge clk);
      t++;
    end
    check("a_finish_seen", XW'(fin_a), XW'(1));
    check("a_finish_lag", XW'(cyc - last_we_a), XW'(1));
    check("a_writes_left", XW'(exp_q_a.size()), XW'(0));
    check("b_writes_left", XW'(exp_q_b.size()), XW'(0));
    check("b_finish", XW'(fin_b), XW'(1));
    check("a_b_ready_busy_after", XW'({rdy_a, busy_a, rdy_b, busy_b}), XW'(0));
    check("b_finish_lag_ok", XW'(last_we_b < cyc), XW'(1));
`ifdef MEMP_PACKER_CHECKSUM_EN
    check("a_checksum", XW'(cs_a), XW'(xa));
    check("b_checksum", XW'(cs_b), XW'(xb));
`else
    check("a_checksum", XW'(cs_a), XW'(0));
    check("b_checksum", XW'(cs_b), XW'(0));
`endif
    if (gap == 0) begin
      check("a_write_count", XW'(we_hist_a.size()), XW'(2));
      if (we_hist_a.size() == 2)
        check("a_write_spacing", XW'(we_hist_a[1] - we_hist_a[0]), XW'(NU));
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_a", XW'({rdy_a, we_a, busy_a, fin_a, addr_a, cs_a}), XW'(0));
    check("reset_a_data", XW'(data_a), XW'(0));
    check("reset_a_state", XW'(st_a), XW'(0));
    @(posedge clk); #1 reset = 1'b0;
    in_valid = 1'b1;
    in_data  = 64'hdead;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_a", XW'({rdy_a, we_a, busy_a, fin_a, addr_a, cs_a}), XW'(0));
      check("idle_b", XW'({rdy_b, we_b, busy_b, fin_b, addr_b, cs_b}), XW'(0));
    end
    @(posedge clk); #1 in_valid = 1'b0;

    // Continuous stream 1..16: A writes two full rows, B a full and a partial row.
    run(1, 0, -1);
    // Same data with 1,0,0 valid pattern.
    run(1, 2, -1);

    // Reset in the middle of a run discards the partial row.
    pulse_start();
    @(negedge clk);
    check("start_ready_busy", XW'({rdy_a, busy_a, fin_a}), XW'(3'b110));
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) feed_one(50 + i, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    check("midreset_a", XW'({rdy_a, we_a, busy_a, fin_a, addr_a}), XW'(0));
    @(posedge clk); #1 reset = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("post_reset_idle", XW'({we_a, fin_a, rdy_a, we_b, fin_b}), XW'(0));
    end

    // Fresh run restarts at base_address; a start pulse mid-FILL is ignored.
    run(101, 0, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test expected finish before 200000");
    $fatal(1, "watchdog");
  end

endmodule
